dual_port_request_scheduler: RTL and testbench
==============================================

# dual_port_request_scheduler

Single-clock front end that feeds the dual-port multi-bank memory and consumes its read data. It buffers requests from two independent requesters (A, B) in per-port 2-entry FIFOs, resolves same-address hazards between the ports, drives the memory's A/B ports, and returns tagged-in-order read responses. Ordering between the ports is deterministic: on a hazard, port A issues first.

## Interface
Parameters:
- WIDTH, 12, data width; matches memory WIDTH
- ADDR_TOTAL, 10, full address width; upper $clog2(NUM_BANK) bits select the bank
- NUM_BANK, 4, bank count; passed through for documentation and assertion only
- MEM_LAT, 1, memory read latency in cycles, from the en/addr edge to o_dout valid; legal range 1..4

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- i_clk  in  1  clock; memory i_clk_a and i_clk_b are tied to it
- i_rst_n  in  1  synchronous active-low reset
- i_req_valid_a / i_req_valid_b  in  1  request valid
- o_req_ready_a / o_req_ready_b  out  1  FIFO not full
- i_req_we_a / i_req_we_b  in  1  1 = write, 0 = read
- i_req_addr_a / i_req_addr_b  in  ADDR_TOTAL  request address
- i_req_din_a / i_req_din_b  in  WIDTH  write data
- o_rsp_valid_a / o_rsp_valid_b  out  1  read data valid, one-cycle pulse, no backpressure
- o_rsp_data_a / o_rsp_data_b  out  WIDTH  read data
- o_mem_en_a / o_mem_en_b  out  1  to memory i_en
- o_mem_we_a / o_mem_we_b  out  1  to memory i_we
- o_mem_addr_a / o_mem_addr_b  out  ADDR_TOTAL  to memory i_addr
- o_mem_din_a / o_mem_din_b  out  WIDTH  to memory i_din
- i_mem_dout_a / i_mem_dout_b  in  WIDTH  from memory o_dout
- o_conflict_cnt  out  16  saturating hazard counter

## Operation

Request path:
- Each port has a 2-entry FIFO holding {we, addr, din}.
- Handshake occurs on valid && ready.
- ready = !full. A push while full never occurs.
- Push and pop in the same cycle are allowed.

Issue:
- o_mem_* is combinational from the FIFO head.
- o_mem_en_x = head_valid_x && !hold_x.
- When en is 0, we/addr/din are driven to 0.

Hazard:
- Condition: both heads valid, addr_a == addr_b, and (we_a || we_b).
- On a hazard: hold_b = 1 and A issues alone; B issues the next cycle.
- Consequences:
  - Write/write: B's data is the final memory value.
  - A write / B read: B reads the new data.
  - A read / B write: A reads the old data.
- Same bank at different addresses is not a hazard; both ports issue.
- hold_a is always 0.

Response path:
- Per port, a MEM_LAT-deep shift register of "read issued" bits is followed by one output register.
- o_rsp_data_x latches i_mem_dout_x when the tap bit is set.
- Writes produce no response.

Conflict counter:
- Increments by 1 each cycle the hazard condition is true.
- Saturates at 0xFFFF.

## Timing
- Reset (i_rst_n = 0 at an edge):
  - FIFOs empty; response pipes cleared.
  - o_req_ready_x = 1; o_rsp_valid_x = 0; o_rsp_data_x = 0.
  - o_mem_en_x = 0; o_conflict_cnt = 0.
- Reset mid-operation: in-flight reads are discarded and no response is emitted for them. Any write already presented on o_mem_* in a completed cycle stands.
- Request accepted at edge k:
  - If it becomes head, o_mem_en is high in cycle k+1 (the cycle following edge k).
  - The memory captures it at edge k+1.
- Read issued in cycle c: o_rsp_valid high in cycle c+MEM_LAT+1 for exactly one cycle.
- Hazard: B issue slips exactly one cycle, and o_req_ready_b deasserts only if its FIFO fills.
- Back-to-back: one issue per port per cycle. Sustained throughput is 1 request/cycle/port when hazard-free.
- Response order per port equals request order. There is no ordering between ports except the A-first rule above.

## Configuration
- SCHED_CONFLICT_CNT_EN defined: the 16-bit saturating hazard counter is implemented.
- SCHED_CONFLICT_CNT_EN undefined:
  - No counter registers are built.
  - o_conflict_cnt is tied to 16'h0.
  - Hazard arbitration is unchanged.

## Test plan
- Reset, then A writes 0xABC to addr 0x005 and reads it back; B idle:
  - Read issued in cycle c gives o_rsp_valid_a in cycle c+2 (MEM_LAT=1) with data 0xABC.
  - No o_rsp_valid_a pulse for the write.
- Same cycle, A writes 0x111 and B writes 0x222, both to addr 0x0F0:
  - A issues first, B issues the next cycle.
  - A later read returns 0x222.
  - o_conflict_cnt = 1.
- Same cycle, A writes 0x3C3 to 0x200 and B reads 0x200: B's response is 0x3C3.
- A and B read 0x010 and 0x020 (same bank, different rows) every cycle for 8 cycles:
  - Both ports issue every cycle.
  - 8 responses each.
  - o_conflict_cnt stays 0.
- Hold i_req_valid_a high for 3 cycles with the head blocked by a B-side conflict pattern:
  - o_req_ready_a never violates full.
  - No requests are lost.
- Assert i_rst_n = 0 one cycle after issuing a read:
  - No o_rsp_valid pulse follows.
  - All outputs are at their reset values on the next cycle.
  - o_conflict_cnt = 0 (it also reads 0 in the build without SCHED_CONFLICT_CNT_EN).

Source files
------------

// File: rtl/dual_port_request_scheduler_if.sv
// Request, response and memory-side bundle of the dual-port request scheduler.
// The scheduler uses the slave modport; the requesters and memory use master.
interface dual_port_request_scheduler_if #(
   parameter int WIDTH      = 12,
   parameter int ADDR_TOTAL = 10
);
   logic                  i_req_valid_a;
   logic                  i_req_valid_b;
   logic                  o_req_ready_a;
   logic                  o_req_ready_b;
   logic                  i_req_we_a;
   logic                  i_req_we_b;
   logic [ADDR_TOTAL-1:0] i_req_addr_a;
   logic [ADDR_TOTAL-1:0] i_req_addr_b;
   logic [WIDTH-1:0]      i_req_din_a;
   logic [WIDTH-1:0]      i_req_din_b;
   logic                  o_rsp_valid_a;
   logic                  o_rsp_valid_b;
   logic [WIDTH-1:0]      o_rsp_data_a;
   logic [WIDTH-1:0]      o_rsp_data_b;
   logic                  o_mem_en_a;
   logic                  o_mem_en_b;
   logic                  o_mem_we_a;
   logic                  o_mem_we_b;
   logic [ADDR_TOTAL-1:0] o_mem_addr_a;
   logic [ADDR_TOTAL-1:0] o_mem_addr_b;
   logic [WIDTH-1:0]      o_mem_din_a;
   logic [WIDTH-1:0]      o_mem_din_b;
   logic [WIDTH-1:0]      i_mem_dout_a;
   logic [WIDTH-1:0]      i_mem_dout_b;
   logic [15:0]           o_conflict_cnt;

   modport slave (
      input  i_req_valid_a, i_req_valid_b, i_req_we_a, i_req_we_b,
      input  i_req_addr_a, i_req_addr_b, i_req_din_a, i_req_din_b,
      input  i_mem_dout_a, i_mem_dout_b,
      output o_req_ready_a, o_req_ready_b, o_rsp_valid_a, o_rsp_valid_b,
      output o_rsp_data_a, o_rsp_data_b, o_mem_en_a, o_mem_en_b,
      output o_mem_we_a, o_mem_we_b, o_mem_addr_a, o_mem_addr_b,
      output o_mem_din_a, o_mem_din_b, o_conflict_cnt
   );

   modport master (
      output i_req_valid_a, i_req_valid_b, i_req_we_a, i_req_we_b,
      output i_req_addr_a, i_req_addr_b, i_req_din_a, i_req_din_b,
      output i_mem_dout_a, i_mem_dout_b,
      input  o_req_ready_a, o_req_ready_b, o_rsp_valid_a, o_rsp_valid_b,
      input  o_rsp_data_a, o_rsp_data_b, o_mem_en_a, o_mem_en_b,
      input  o_mem_we_a, o_mem_we_b, o_mem_addr_a, o_mem_addr_b,
      input  o_mem_din_a, o_mem_din_b, o_conflict_cnt
   );
endinterface

// File: rtl/dual_port_request_scheduler.sv
// Two-port request scheduler: per-port 2-entry FIFOs, A-first same-address hazard
// arbitration, in-order read responses. Macro SCHED_CONFLICT_CNT_EN adds the hazard counter.
module dual_port_request_scheduler #(
   parameter int WIDTH      = 12,
   parameter int ADDR_TOTAL = 10,
   parameter int NUM_BANK   = 4,
   parameter int MEM_LAT    = 1
) (
   input logic                     i_clk,
   input logic                     i_rst_n,
   dual_port_request_scheduler_if.slave bus
);
   localparam int NP = 2;

   typedef struct packed {
      logic                  we;
      logic [ADDR_TOTAL-1:0] addr;
      logic [WIDTH-1:0]      din;
   } req_t;

   logic             req_valid  [NP];
   req_t             req_in     [NP];
   logic             req_ready  [NP];
   logic             head_valid [NP];
   req_t             head       [NP];
   logic             hold       [NP];
   logic             issue      [NP];
   logic [WIDTH-1:0] mem_dout   [NP];
   logic             rsp_valid  [NP];
   logic [WIDTH-1:0] rsp_data   [NP];
   logic             hazard;

   assign req_valid[0] = bus.i_req_valid_a;
   assign req_valid[1] = bus.i_req_valid_b;
   assign req_in[0]    = {bus.i_req_we_a, bus.i_req_addr_a, bus.i_req_din_a};
   assign req_in[1]    = {bus.i_req_we_b, bus.i_req_addr_b, bus.i_req_din_b};
   assign mem_dout[0]  = bus.i_mem_dout_a;
   assign mem_dout[1]  = bus.i_mem_dout_b;

   // Same address with at least one write: B waits so A's access lands first.
   assign hazard  = head_valid[0] && head_valid[1] &&
                    (head[0].addr == head[1].addr) && (head[0].we || head[1].we);
   assign hold[0] = 1'b0;
   assign hold[1] = hazard;

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_port
         req_t             slot_reg [2];
         logic             wr_ptr_reg;
         logic             rd_ptr_reg;
         logic [1:0]       count_reg;
         logic             push;
         logic             pop;
         logic [MEM_LAT-1:0] rd_pipe_reg;
         logic             rsp_valid_reg;
         logic [WIDTH-1:0] rsp_data_reg;

         assign req_ready[gi]  = (count_reg != 2'd2);
         assign push           = req_valid[gi] && req_ready[gi];
         assign pop            = issue[gi];
         assign head_valid[gi] = (count_reg != 2'd0);
         assign head[gi]       = slot_reg[rd_ptr_reg];
         assign issue[gi]      = head_valid[gi] && !hold[gi];

         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               wr_ptr_reg <= 1'b0;
               rd_ptr_reg <= 1'b0;
               count_reg  <= 2'd0;
            end else begin
               if (push) begin
                  slot_reg[wr_ptr_reg] <= req_in[gi];
                  wr_ptr_reg           <= !wr_ptr_reg;
               end
               if (pop) begin
                  rd_ptr_reg <= !rd_ptr_reg;
               end
               count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
            end
         end

         // Read-issued bits track the memory latency; the tap qualifies the memory output.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               rd_pipe_reg   <= '0;
               rsp_valid_reg <= 1'b0;
               rsp_data_reg  <= '0;
            end else begin
               for (int i = MEM_LAT - 1; i > 0; i--) begin
                  rd_pipe_reg[i] <= rd_pipe_reg[i-1];
               end
               rd_pipe_reg[0] <= issue[gi] && !head[gi].we;
               rsp_valid_reg  <= rd_pipe_reg[MEM_LAT-1];
               if (rd_pipe_reg[MEM_LAT-1]) begin
                  rsp_data_reg <= mem_dout[gi];
               end
            end
         end

         assign rsp_valid[gi] = rsp_valid_reg;
         assign rsp_data[gi]  = rsp_data_reg;
      end
   endgenerate

   assign bus.o_req_ready_a = req_ready[0];
   assign bus.o_req_ready_b = req_ready[1];
   assign bus.o_rsp_valid_a = rsp_valid[0];
   assign bus.o_rsp_valid_b = rsp_valid[1];
   assign bus.o_rsp_data_a  = rsp_data[0];
   assign bus.o_rsp_data_b  = rsp_data[1];

   assign bus.o_mem_en_a    = issue[0];
   assign bus.o_mem_we_a    = issue[0] && head[0].we;
   assign bus.o_mem_addr_a  = issue[0] ? head[0].addr : '0;
   assign bus.o_mem_din_a   = issue[0] ? head[0].din  : '0;
   assign bus.o_mem_en_b    = issue[1];
   assign bus.o_mem_we_b    = issue[1] && head[1].we;
   assign bus.o_mem_addr_b  = issue[1] ? head[1].addr : '0;
   assign bus.o_mem_din_b   = issue[1] ? head[1].din  : '0;

`ifdef SCHED_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt_reg;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         conflict_cnt_reg <= 16'h0;
      end else if (hazard && (conflict_cnt_reg != 16'hFFFF)) begin
         conflict_cnt_reg <= conflict_cnt_reg + 16'h1;
      end
   end

   assign bus.o_conflict_cnt = conflict_cnt_reg;
`else
   assign bus.o_conflict_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_dual_port_request_scheduler.sv
// Randomized and directed scoreboard bench for dual_port_request_scheduler with a
// behavioural memory; reference memory is updated in request order, A before B.
module tb_dual_port_request_scheduler;
   localparam int W  = 12;
   localparam int AT = 10;
   localparam int ML = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dual_port_request_scheduler_if #(.WIDTH(W), .ADDR_TOTAL(AT)) bus ();

   dual_port_request_scheduler #(
      .WIDTH(W), .ADDR_TOTAL(AT), .NUM_BANK(4), .MEM_LAT(ML)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   // Behavioural memory with ML cycles of read latency.
   logic [W-1:0] mem [1024];
   logic [W-1:0] dpa [ML];
   logic [W-1:0] dpb [ML];
   always @(posedge clk) begin
      for (int i = ML - 1; i > 0; i--) begin
         dpa[i] <= dpa[i-1];
         dpb[i] <= dpb[i-1];
      end
      if (bus.o_mem_en_a) begin
         if (bus.o_mem_we_a) mem[bus.o_mem_addr_a] <= bus.o_mem_din_a;
         else dpa[0] <= mem[bus.o_mem_addr_a];
      end
      if (bus.o_mem_en_b) begin
         if (bus.o_mem_we_b) mem[bus.o_mem_addr_b] <= bus.o_mem_din_b;
         else dpb[0] <= mem[bus.o_mem_addr_b];
      end
   end
   assign bus.i_mem_dout_a = dpa[ML-1];
   assign bus.i_mem_dout_b = dpb[ML-1];

   logic [W-1:0] ref_mem [1024];
   logic [W-1:0] exp_a [$];
   logic [W-1:0] exp_b [$];
   int           iss_a [$];
   int           iss_b [$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_cnt = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] cnt_exp();
`ifdef SCHED_CONFLICT_CNT_EN
      return exp_cnt[15:0];
`else
      return 16'h0;
`endif
   endfunction

   // Monitor: record read issue cycles, pop and compare on each response.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_mem_en_a && !bus.o_mem_we_a) iss_a.push_back(cyc);
         if (bus.o_mem_en_b && !bus.o_mem_we_b) iss_b.push_back(cyc);
      end
      if (!bus.o_mem_en_a)
         chk("idle_bus_a", {bus.o_mem_we_a, bus.o_mem_addr_a, bus.o_mem_din_a}, 0);
      if (!bus.o_mem_en_b)
         chk("idle_bus_b", {bus.o_mem_we_b, bus.o_mem_addr_b, bus.o_mem_din_b}, 0);
      if (bus.o_rsp_valid_a) begin
         if (exp_a.size() == 0 || iss_a.size() == 0) chk("rsp_a_unexpected", 1, 0);
         else begin
            $display("rsp A data=%03h cycle=%0d", bus.o_rsp_data_a, cyc);
            chk("rsp_a_data", bus.o_rsp_data_a, exp_a.pop_front());
            chk("rsp_a_latency", cyc - iss_a.pop_front(), ML + 1);
         end
      end
      if (bus.o_rsp_valid_b) begin
         if (exp_b.size() == 0 || iss_b.size() == 0) chk("rsp_b_unexpected", 1, 0);
         else begin
            $display("rsp B data=%03h cycle=%0d", bus.o_rsp_data_b, cyc);
            chk("rsp_b_data", bus.o_rsp_data_b, exp_b.pop_front());
            chk("rsp_b_latency", cyc - iss_b.pop_front(), ML + 1);
         end
      end
   end

   // One cycle of stimulus; returns at posedge+1 with valids dropped.
   task automatic drive(input bit va, input bit wa, input logic [AT-1:0] aa, input logic [W-1:0] da,
                        input bit vb, input bit wb, input logic [AT-1:0] ab, input logic [W-1:0] db,
                        input bit model, output bit acc_a, output bit acc_b);
      @(negedge clk);
      bus.i_req_valid_a = va; bus.i_req_we_a = wa; bus.i_req_addr_a = aa; bus.i_req_din_a = da;
      bus.i_req_valid_b = vb; bus.i_req_we_b = wb; bus.i_req_addr_b = ab; bus.i_req_din_b = db;
      acc_a = va && bus.o_req_ready_a;
      acc_b = vb && bus.o_req_ready_b;
      if (model) begin
         if (acc_a) begin
            if (wa) ref_mem[aa] = da;
            else exp_a.push_back(ref_mem[aa]);
         end
         if (acc_b) begin
            if (wb) ref_mem[ab] = db;
            else exp_b.push_back(ref_mem[ab]);
         end
      end
      @(posedge clk);
      #1;
      bus.i_req_valid_a = 1'b0;
      bus.i_req_valid_b = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge clk);
      chk(name, exp_a.size() + exp_b.size(), 0);
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, "_ready"}, {bus.o_req_ready_a, bus.o_req_ready_b}, 2'b11);
      chk({name, "_rsp_valid"}, {bus.o_rsp_valid_a, bus.o_rsp_valid_b}, 2'b00);
      chk({name, "_rsp_data"}, {bus.o_rsp_data_a, bus.o_rsp_data_b}, 0);
      chk({name, "_mem_en"}, {bus.o_mem_en_a, bus.o_mem_en_b}, 2'b00);
      chk({name, "_conflict_cnt"}, bus.o_conflict_cnt, 0);
   endtask

   bit aa_ok, ab_ok;
   bit pav, paw, pbv, pbw;
   logic [AT-1:0] paa, pba;
   logic [W-1:0]  pad, pbd, d3;

   initial begin
      bus.i_req_valid_a = 0; bus.i_req_we_a = 0; bus.i_req_addr_a = 0; bus.i_req_din_a = 0;
      bus.i_req_valid_b = 0; bus.i_req_we_b = 0; bus.i_req_addr_b = 0; bus.i_req_din_b = 0;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      for (int i = 0; i < ML; i++) begin
         dpa[i] = '0;
         dpb[i] = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // A writes then reads back; B idle.
      drive(1, 1, 10'h005, 12'hABC, 0, 0, 0, 0, 1, aa_ok, ab_ok);
      drive(1, 0, 10'h005, 12'h000, 0, 0, 0, 0, 1, aa_ok, ab_ok);
      idle(5);
      drain("t1_drain");

      // Write/write hazard: A issues alone, B the next cycle.
      drive(1, 1, 10'h0F0, 12'h111, 1, 1, 10'h0F0, 12'h222, 1, aa_ok, ab_ok);
      exp_cnt++;
      chk("ww_first_a", {bus.o_mem_en_a, bus.o_mem_we_a, bus.o_mem_addr_a, bus.o_mem_din_a},
          {1'b1, 1'b1, 10'h0F0, 12'h111});
      chk("ww_first_b_held", bus.o_mem_en_b, 0);
      @(posedge clk);
      #1;
      chk("ww_second_b", {bus.o_mem_en_b, bus.o_mem_we_b, bus.o_mem_addr_b, bus.o_mem_din_b},
          {1'b1, 1'b1, 10'h0F0, 12'h222});
      chk("ww_second_a_idle", bus.o_mem_en_a, 0);
      idle(2);
      drive(1, 0, 10'h0F0, 0, 0, 0, 0, 0, 1, aa_ok, ab_ok);
      idle(4);
      chk("ww_conflict_cnt", bus.o_conflict_cnt, cnt_exp());

      // A write / B read, then A read / B write, on the same address.
      drive(1, 1, 10'h200, 12'h3C3, 1, 0, 10'h200, 0, 1, aa_ok, ab_ok);
      exp_cnt++;
      idle(4);
      drive(1, 0, 10'h200, 0, 1, 1, 10'h200, 12'h155, 1, aa_ok, ab_ok);
      exp_cnt++;
      idle(4);
      drive(0, 0, 0, 0, 1, 0, 10'h200, 0, 1, aa_ok, ab_ok);
      idle(4);
      drain("t3_drain");
      chk("rw_conflict_cnt", bus.o_conflict_cnt, cnt_exp());

      // Same bank, different rows: both ports issue every cycle.
      drive(1, 1, 10'h010, 12'h5A5, 1, 1, 10'h020, 12'h6B6, 1, aa_ok, ab_ok);
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 10'h010, 0, 1, 0, 10'h020, 0, 1, aa_ok, ab_ok);
         chk("bank_both_issue", {bus.o_mem_en_a, bus.o_mem_en_b}, 2'b11);
      end
      idle(4);
      drain("t4_drain");
      chk("bank_conflict_cnt", bus.o_conflict_cnt, cnt_exp());

      // A streams writes to one address while B reads it: B waits out every A write.
      d3 = 12'h7E7;
      drive(1, 1, 10'h300, 12'h701, 1, 0, 10'h300, 0, 0, aa_ok, ab_ok);
      chk("stream_acc_a0", {aa_ok, ab_ok}, 2'b11);
      drive(1, 1, 10'h300, 12'h702, 0, 0, 0, 0, 0, aa_ok, ab_ok);
      chk("stream_acc_a1", aa_ok, 1);
      drive(1, 1, 10'h300, d3, 0, 0, 0, 0, 0, aa_ok, ab_ok);
      chk("stream_acc_a2", aa_ok, 1);
      ref_mem[10'h300] = d3;
      exp_b.push_back(d3);
      exp_cnt += 3;
      idle(6);
      drain("t5_drain");
      chk("stream_conflict_cnt", bus.o_conflict_cnt, cnt_exp());

      // Random hazard-free traffic with held-valid protocol.
      pav = 0; pbv = 0;
      for (int i = 0; i < 400; i++) begin
         if (!pav && ($urandom_range(0, 3) != 0)) begin
            pav = 1; paw = $urandom_range(0, 1) == 1;
            paa = AT'($urandom_range(0, 127)); pad = W'($urandom);
         end
         if (!pbv && ($urandom_range(0, 3) != 0)) begin
            pbv = 1; pbw = $urandom_range(0, 1) == 1;
            pba = AT'($urandom_range(128, 255)); pbd = W'($urandom);
         end
         drive(pav, paw, paa, pad, pbv, pbw, pba, pbd, 1, aa_ok, ab_ok);
         if (aa_ok) pav = 0;
         if (ab_ok) pbv = 0;
      end
      idle(4);
      drain("rand_drain");
      chk("rand_conflict_cnt", bus.o_conflict_cnt, cnt_exp());

      // Reset one cycle after a read issues: the response must never appear.
      drive(1, 0, 10'h005, 0, 1, 0, 10'h0F0, 0, 0, aa_ok, ab_ok);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      iss_a.delete();
      iss_b.delete();
      exp_cnt = 0;
      chk_reset_state("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(6);
      chk("post_reset_rsp", {bus.o_rsp_valid_a, bus.o_rsp_valid_b}, 2'b00);
      chk("post_reset_cnt", bus.o_conflict_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
